// File: rtl/fetch_queue_if.sv
// fetch_queue_if: F-stage and D-stage signals of the instruction fetch buffer.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised by a producer, carries stable data for that cycle,
// and ready never depends combinationally on the other side's valid.
interface fetch_queue_if;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_valid;
    logic        f_ready;
    logic        flush;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [4:0]  d_exc;
    logic        d_valid;
    logic        d_ready;

    // Environment side: fetch stage, decode stage and redirect source.
    modport master (
        output f_pc, f_instr, f_valid, flush, d_ready,
        input  f_ready, d_pc, d_instr, d_exc, d_valid
    );

    // Queue side.
    modport slave (
        input  f_pc, f_instr, f_valid, flush, d_ready,
        output f_ready, d_pc, d_instr, d_exc, d_valid
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry buffer of fetched {pc, instr} pairs between the PC
// register / instruction memory and decode. f_ready drives the PC register
// enable and depends on registered occupancy only.
// Optional feature: define FETCH_ADEL_CHECK_EN to tag misaligned or
// out-of-range fetch PCs with exception code 4 (AdEL) and replace the
// instruction with a nop.
module fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.slave  fq
);

    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic push;
    logic pop;
    logic empty;

    logic [31:0] wr_instr;
`ifdef FETCH_ADEL_CHECK_EN
    logic [4:0]  exc_mem [DEPTH];
    logic        addr_bad;
    logic [4:0]  wr_exc;
`endif

    assign empty      = (count == '0);
    assign fq.f_ready = (count != FULL);
    assign fq.d_valid = !empty;

    // Flush kills both sides of the handshake for this cycle.
    assign push = fq.f_valid & fq.f_ready & ~fq.flush;
    assign pop  = fq.d_valid & fq.d_ready & ~fq.flush;

`ifdef FETCH_ADEL_CHECK_EN
    // Fetch address must be word aligned and inside the text segment.
    assign addr_bad = (fq.f_pc[1:0] != 2'b00) ||
                      (fq.f_pc < 32'h0000_3000) ||
                      (fq.f_pc > 32'h0000_6ffc);
    assign wr_exc   = addr_bad ? 5'd4 : 5'd0;
    assign wr_instr = addr_bad ? 32'h0000_0000 : fq.f_instr;
`else
    assign wr_instr = fq.f_instr;
`endif

    // Storage write; contents are don't-care until occupied, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fq.f_pc;
            instr_mem[wr_ptr] <= wr_instr;
`ifdef FETCH_ADEL_CHECK_EN
            exc_mem[wr_ptr]   <= wr_exc;
`endif
        end
    end

    // Pointers and occupancy; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (reset || fq.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head entry; an empty queue shows the reset PC and a clean nop.
    always_comb begin
        fq.d_pc    = RESET_PC;
        fq.d_instr = 32'h0000_0000;
        fq.d_exc   = 5'd0;
        if (!empty) begin
            fq.d_pc    = pc_mem[rd_ptr];
            fq.d_instr = instr_mem[rd_ptr];
`ifdef FETCH_ADEL_CHECK_EN
            fq.d_exc   = exc_mem[rd_ptr];
`endif
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed test-plan sequences plus randomized traffic checked
// against a queue-based reference model of the fetch buffer.
module tb_fetch_queue;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } ent_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if fq ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq)
    );

    // ---------------- scoreboard ----------------
    ent_t model_q[$];
    bit   model_known = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t make_entry(input logic [31:0] pc, input logic [31:0] instr);
        ent_t e;
        bit   bad;
        e.pc = pc;
`ifdef FETCH_ADEL_CHECK_EN
        bad = (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
`else
        bad = 1'b0;
`endif
        e.instr = bad ? 32'h0 : instr;
        e.exc   = bad ? 5'd4  : 5'd0;
        return e;
    endfunction

    task automatic check_outputs(input string when);
        logic [31:0] exp_pc, exp_instr;
        logic [4:0]  exp_exc;
        exp_pc    = RESET_PC;
        exp_instr = 32'h0;
        exp_exc   = 5'd0;
        if (model_q.size() != 0) begin
            exp_pc    = model_q[0].pc;
            exp_instr = model_q[0].instr;
            exp_exc   = model_q[0].exc;
        end
        check({when, " d_valid"}, 64'(fq.d_valid), 64'(model_q.size() != 0));
        check({when, " f_ready"}, 64'(fq.f_ready), 64'(model_q.size() != DEPTH));
        check({when, " d_pc"},    64'(fq.d_pc),    64'(exp_pc));
        check({when, " d_instr"}, 64'(fq.d_instr), 64'(exp_instr));
        check({when, " d_exc"},   64'(fq.d_exc),   64'(exp_exc));
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs, verify outputs before the edge (no path from
    // the inputs to the outputs), advance the model, verify after the edge.
    task automatic cycle(input logic rst, input logic fv, input logic [31:0] pc,
                         input logic [31:0] instr, input logic fl, input logic dr);
        bit can_push, can_pop;
        reset      = rst;
        fq.f_valid = fv;
        fq.f_pc    = pc;
        fq.f_instr = instr;
        fq.flush   = fl;
        fq.d_ready = dr;
        #1;
        if (model_known) check_outputs("pre");
        if (rst || fl) begin
            model_q.delete();
        end else begin
            can_push = fv && (model_q.size() < DEPTH);
            can_pop  = dr && (model_q.size() > 0);
            if (can_pop)  void'(model_q.pop_front());
            if (can_push) model_q.push_back(make_entry(pc, instr));
        end
        model_known = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post");
    endtask

    task automatic idle(input logic dr);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, dr);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        fq.f_valid = 1'b0;
        fq.f_pc    = 32'h0;
        fq.f_instr = 32'h0;
        fq.flush   = 1'b0;
        fq.d_ready = 1'b0;

        // Reset state
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset d_valid", 64'(fq.d_valid), 64'd0);
        check("reset f_ready", 64'(fq.f_ready), 64'd1);
        check("reset d_pc",    64'(fq.d_pc),    64'h3000);

        // Single push, decode stalled
        cycle(1'b0, 1'b1, 32'h3000, 32'h3c01_0001, 1'b0, 1'b0);
        check("push1 d_pc",    64'(fq.d_pc),    64'h3000);
        check("push1 d_instr", 64'(fq.d_instr), 64'h3c01_0001);
        check("push1 f_ready", 64'(fq.f_ready), 64'd1);

        // Fill, reject a third offer, then drain in order
        cycle(1'b0, 1'b1, 32'h3004, 32'h1111_0004, 1'b0, 1'b0);
        check("full f_ready", 64'(fq.f_ready), 64'd0);
        cycle(1'b0, 1'b1, 32'h3008, 32'h1111_0008, 1'b0, 1'b0);
        check("reject d_pc", 64'(fq.d_pc), 64'h3000);
        // Full with push+pop offered: pop only
        cycle(1'b0, 1'b1, 32'h3008, 32'h1111_0008, 1'b0, 1'b1);
        check("pop-only d_pc",    64'(fq.d_pc),    64'h3004);
        check("pop-only f_ready", 64'(fq.f_ready), 64'd1);
        idle(1'b1);
        check("drained d_valid", 64'(fq.d_valid), 64'd0);

        // Streaming: one entry per cycle, pointers wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 32'h3000 + 32'(4 * i), 32'habcd_0000 + 32'(i), 1'b0, 1'b1);
            check("stream d_pc", 64'(fq.d_pc), 64'(32'h3000 + 32'(4 * i)));
        end
        idle(1'b1);

        // Flush with two held entries and a concurrent offer
        cycle(1'b0, 1'b1, 32'h3040, 32'h2, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h3044, 32'h3, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h3100, 32'h4, 1'b1, 1'b0);
        check("flush d_valid", 64'(fq.d_valid), 64'd0);
        check("flush d_pc",    64'(fq.d_pc),    64'h3000);
        check("flush f_ready", 64'(fq.f_ready), 64'd1);

        // Address check boundaries (expectations follow the build option)
        cycle(1'b0, 1'b1, 32'h3002, 32'h5555_5555, 1'b0, 1'b0);
        check("adel 3002 d_pc", 64'(fq.d_pc), 64'h3002);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h7000, 32'h6666_6666, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h6ffc, 32'h7777_7777, 1'b0, 1'b0);
        check("adel 6ffc d_exc", 64'(fq.d_exc), 64'd0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h2ffc, 32'h8888_8888, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            case ($urandom_range(0, 7))
                0:       pc = $urandom;
                1:       pc = 32'h3000 + 32'($urandom_range(0, 32'h4000));
                2:       pc = ($urandom_range(0, 1) != 0) ? 32'h6ffc : 32'h7000;
                default: pc = 32'h3000 + 32'(4 * $urandom_range(0, 32'hfff));
            endcase
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0),
                  pc, $urandom,
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        // Mid-operation reset discards entries
        cycle(1'b0, 1'b1, 32'h3200, 32'h9, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h3204, 32'ha, 1'b0, 1'b0);
        check("midreset d_valid", 64'(fq.d_valid), 64'd0);
        check("midreset d_pc",    64'(fq.d_pc),    64'h3000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch buffer between the PC register / instruction memory (F stage) and the decode stage (D). It holds up to DEPTH fetched {pc, instr} pairs, decouples PC advance from decode stalls through a valid/ready handshake, and drives the PC register enable through `f_ready`. A `flush` input discards all buffered entries on redirect. An optional fetch-address check tags bad PCs with an exception code.

## Interface
- `DEPTH`, 2, number of entries; power of two, ≥2
- `RESET_PC`, 32'h0000_3000, value presented on `d_pc` while the queue is empty after reset
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `f_pc`  in  32  PC of the instruction being fetched (PC register output)
- `f_instr`  in  32  instruction memory read data for `f_pc`
- `f_valid`  in  1  F-stage offers an entry this cycle
- `f_ready`  out  1  queue can accept; drives the PC register `en`
- `flush`  in  1  discard all entries (redirect)
- `d_pc`  out  32  PC of the head entry
- `d_instr`  out  32  instruction of the head entry
- `d_exc`  out  5  exception code of the head entry; 0 means none
- `d_valid`  out  1  head entry valid
- `d_ready`  in  1  D stage consumes the head this cycle

## Operation
- State: DEPTH-entry storage of {pc[31:0], instr[31:0], exc[4:0]}, write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits).
- Push = `f_valid & f_ready & ~flush`: writes entry at write pointer, write pointer +1.
- Pop = `d_valid & d_ready & ~flush`: read pointer +1.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- `f_ready = (count != DEPTH)`. It depends on registered state only and never on `d_ready`. When full, a simultaneous pop does not allow a push that cycle.
- `d_valid = (count != 0)`. `d_pc`, `d_instr` and `d_exc` are read combinationally from the entry at the read pointer.
- When empty: `d_pc` = RESET_PC, `d_instr` = 0, `d_exc` = 0, regardless of stale storage.
- `flush`: next edge sets count, write pointer and read pointer to 0. Any push or pop in the flush cycle is ignored. `flush` has priority over everything except `reset`.
- `reset` has priority over `flush` and all handshakes. Storage contents need not be reset.

## Timing
- Latency: an entry pushed at edge N is visible with `d_valid`=1 from just after edge N. No combinational path from `f_*` to `d_*`.
- `f_ready` falls the cycle after the push that fills the queue. It rises the cycle after the first pop from full.
- `d_valid` falls the cycle after the pop of the last entry, unless a push occurs in the same cycle.
- After `reset` or `flush`: `d_valid`=0, `f_ready`=1, `d_pc`=RESET_PC, `d_instr`=0, `d_exc`=0 from the next cycle.
- Reset asserted mid-operation discards all entries exactly as flush does.

## Configuration
- `FETCH_ADEL_CHECK_EN` defined: on push, if `f_pc[1:0] != 0`, or `f_pc < 32'h0000_3000`, or `f_pc > 32'h0000_6ffc`:
  - the stored exc is 5'd4 (AdEL);
  - the stored instr is 32'h0000_0000 (nop);
  - the stored pc is the faulting `f_pc`.
  Otherwise the stored exc is 0.
- `FETCH_ADEL_CHECK_EN` not defined: no check. The exc field is not stored, `d_exc` is tied to 0, and instructions pass unmodified.

## Test plan
- Reset, then push pc 0x3000/instr 0x3c010001 with `d_ready`=0 -> next cycle `d_valid`=1, `d_pc`=0x3000, `d_instr`=0x3c010001, `f_ready`=1.
- DEPTH=2, `d_ready`=0, push pcs 0x3000 and 0x3004 -> `f_ready`=0 after the 2nd push. A third `f_valid` is not accepted. Raise `d_ready` -> outputs 0x3000 then 0x3004 in order.
- Full queue, `f_valid`=1 and `d_ready`=1 together -> pop only. Count goes 2→1, the push is rejected, `f_ready`=1 next cycle.
- Continuous `f_valid` and `d_ready` for 10 cycles from 0x3000 -> one entry per cycle, pointers wrap, `d_pc` sequence 0x3000…0x3024 with no gaps or duplicates.
- Two entries held, assert `flush` with `f_valid`=1 pc 0x3100 -> next cycle `d_valid`=0, `d_pc`=0x3000. The 0x3100 entry is not stored.
- With `FETCH_ADEL_CHECK_EN`, push pc 0x3002 -> `d_exc`=4, `d_instr`=0, `d_pc`=0x3002. Push pc 0x7000 -> `d_exc`=4. Push pc 0x6ffc -> `d_exc`=0.
